simd_execute_pipe: RTL and testbench

- Next-generation SIMD execute stage: applies one ALU operation element-wise to two vector operands, LANES elements per cycle, over VEC_SIZE/LANES cycles.
- Adds a per-element write mask, a valid/ready handshake on both sides, and N/Z flags accumulated across all chunks.
- Evaluates the branch condition against the flag register.
- Sits between decode/register-read and writeback, and drives the PC write enable.

---
 rtl/simd_pkg.sv | 35 +++
 rtl/simd_lane_alu.sv | 37 +++
 rtl/simd_execute_pipe.sv | 170 +++++++++++++++++
 tb/tb_simd_execute_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD execute stage: ALU op codes, branch selects, FSM states.
package simd_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_SRL  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    localparam logic [2:0] BR_NE = 3'b100;
    localparam logic [2:0] BR_EQ = 3'b010;
    localparam logic [2:0] BR_LT = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // nz = {Z, N}
    function automatic logic branch_taken(input logic [2:0] sel, input logic [1:0] nz);
        case (sel)
            BR_NE:   return ~nz[1];
            BR_EQ:   return nz[1];
            BR_LT:   return nz[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// Single-element combinational ALU; wrap-around arithmetic, shift amount from low bits of b.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  alu_op_e             op,
    input  logic [REG_SIZE-1:0] a,
    input  logic [REG_SIZE-1:0] b,
    output logic [REG_SIZE-1:0] result,
    output logic                neg,
    output logic                zero
);

    localparam int SH_W = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            default: result = a;
        endcase
    end

    assign neg  = result[REG_SIZE-1];
    assign zero = (result == '0);

endmodule

// File: rtl/simd_execute_pipe.sv
// SIMD execute stage: element-wise ALU over a vector, LANES elements per cycle,
// with write mask, N/Z accumulation, branch evaluation and valid/ready handshakes.
module simd_execute_pipe
    import simd_pkg::*;
#(
    parameter int REG_SIZE = 8,
    parameter int VEC_SIZE = 16,
    parameter int LANES    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2:0]                         execute_op,
    input  logic                               overwrite_flags,
    input  logic [2:0]                         pc_wr_en,
    input  logic [VEC_SIZE-1:0]                lane_mask,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vect1,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vect2,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vect_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               pc_wr_en_out,
    output logic [1:0]                         nz_flags
);

    localparam int CHUNKS = VEC_SIZE / LANES;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IDX_W  = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

    if (VEC_SIZE % LANES != 0) begin : g_bad_cfg
        $error("simd_execute_pipe: VEC_SIZE must be a multiple of LANES");
    end

    state_e                              state_q, state_d;
    alu_op_e                             op_q, op_d;
    logic                                ovw_q, ovw_d;
    logic [VEC_SIZE-1:0]                 mask_q, mask_d;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]   v1_q, v1_d, v2_q, v2_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                acc_n_q, acc_n_d, acc_z_q, acc_z_d;
    logic                                br_q, br_d;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]   vect_out_q, vect_out_d;
    logic                                out_valid_q, out_valid_d;
    logic                                pc_out_q, pc_out_d;
    logic [1:0]                          flags_q, flags_d;

    logic [IDX_W-1:0]                    lane_idx [LANES];
    logic [LANES-1:0][REG_SIZE-1:0]      lane_a, lane_b, lane_res;
    logic [LANES-1:0]                    lane_neg, lane_zero;

    // Each lane reads element k*LANES + l of the latched operands.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(cnt_q) * IDX_W'(LANES) + IDX_W'(l);
        assign lane_a[l]   = v1_q[lane_idx[l]];
        assign lane_b[l]   = v2_q[lane_idx[l]];

        simd_lane_alu #(.REG_SIZE(REG_SIZE)) u_alu (
            .op     (op_q),
            .a      (lane_a[l]),
            .b      (lane_b[l]),
            .result (lane_res[l]),
            .neg    (lane_neg[l]),
            .zero   (lane_zero[l])
        );
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ovw_d       = ovw_q;
        mask_d      = mask_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        cnt_d       = cnt_q;
        acc_n_d     = acc_n_q;
        acc_z_d     = acc_z_q;
        br_d        = br_q;
        vect_out_d  = vect_out_q;
        out_valid_d = out_valid_q;
        pc_out_d    = pc_out_q;
        flags_d     = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    op_d    = alu_op_e'(execute_op);
                    ovw_d   = overwrite_flags;
                    mask_d  = lane_mask;
                    v1_d    = vect1;
                    v2_d    = vect2;
                    cnt_d   = '0;
                    acc_n_d = 1'b0;
                    acc_z_d = 1'b1;
                    // Uses the flags left by the previous operation.
                    br_d    = branch_taken(pc_wr_en, flags_q);
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    if (mask_q[lane_idx[l]]) begin
                        vect_out_d[lane_idx[l]] = lane_res[l];
                        acc_n_d = acc_n_d | lane_neg[l];
                        acc_z_d = acc_z_d & lane_zero[l];
                    end else begin
                        vect_out_d[lane_idx[l]] = v1_q[lane_idx[l]];
                    end
                end
                if (cnt_q == CNT_W'(CHUNKS - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    pc_out_d    = br_q;
                    if (ovw_q) flags_d = {acc_z_d, acc_n_d};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    pc_out_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            ovw_q       <= 1'b0;
            mask_q      <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            cnt_q       <= '0;
            acc_n_q     <= 1'b0;
            acc_z_q     <= 1'b1;
            br_q        <= 1'b0;
            vect_out_q  <= '0;
            out_valid_q <= 1'b0;
            pc_out_q    <= 1'b0;
            flags_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ovw_q       <= ovw_d;
            mask_q      <= mask_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            cnt_q       <= cnt_d;
            acc_n_q     <= acc_n_d;
            acc_z_q     <= acc_z_d;
            br_q        <= br_d;
            vect_out_q  <= vect_out_d;
            out_valid_q <= out_valid_d;
            pc_out_q    <= pc_out_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign vect_out     = vect_out_q;
    assign out_valid    = out_valid_q;
    assign pc_wr_en_out = pc_out_q;
    assign nz_flags     = flags_q;

endmodule

// File: tb/tb_simd_execute_pipe.sv
// Bench for simd_execute_pipe: hand-derived vector table, reset/backpressure
// sequences, and randomized ops against an element-wise reference model.
module tb_simd_execute_pipe;

    localparam int RS = 8;
    localparam int VS = 16;
    localparam int LN = 4;
    localparam int LAT = VS / LN;

    typedef logic [VS-1:0][RS-1:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  execute_op;
    logic        overwrite_flags;
    logic [2:0]  pc_wr_en;
    logic [VS-1:0] lane_mask;
    vec_t        vect1, vect2, vect_out;
    logic        out_valid;
    logic        out_ready;
    logic        pc_wr_en_out;
    logic [1:0]  nz_flags;

    int n_chk = 0;
    int n_fail = 0;

    simd_execute_pipe #(.REG_SIZE(RS), .VEC_SIZE(VS), .LANES(LN)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .execute_op      (execute_op),
        .overwrite_flags (overwrite_flags),
        .pc_wr_en        (pc_wr_en),
        .lane_mask       (lane_mask),
        .vect1           (vect1),
        .vect2           (vect2),
        .vect_out        (vect_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc_wr_en_out    (pc_wr_en_out),
        .nz_flags        (nz_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain element arithmetic, flags from the set of active results.
    function automatic logic [RS-1:0] ref_elem(input logic [2:0] op, input logic [RS-1:0] a, input logic [RS-1:0] b);
        int sh;
        int r;
        sh = b % RS;
        case (op)
            3'd0: r = (a + b) % 256;
            3'd1: r = (a - b + 256) % 256;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a * (1 << sh)) % 256;
            3'd6: r = a / (1 << sh);
            default: r = a;
        endcase
        return RS'(r);
    endfunction

    function automatic logic ref_branch(input logic [2:0] sel, input logic [1:0] zn);
        if (sel == 3'b100) return !zn[1];
        if (sel == 3'b010) return zn[1];
        if (sel == 3'b001) return zn[0];
        return 1'b0;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic ovw, input logic [2:0] br,
                         input logic [VS-1:0] mask, input vec_t v1, input vec_t v2,
                         input vec_t exp_vec, input logic [1:0] exp_flags, input logic exp_br, input int hold);
        int lat;
        for (int n = 0; n < 20 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, " in_ready"}, in_ready, 1'b1);
        execute_op = op; overwrite_flags = ovw; pc_wr_en = br;
        lane_mask = mask; vect1 = v1; vect2 = v2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vect1 = '0; vect2 = '0; lane_mask = '0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " vect_out"}, vect_out, exp_vec);
        chk({tag, " pc_wr_en_out"}, pc_wr_en_out, exp_br);
        chk({tag, " nz_flags"}, nz_flags, exp_flags);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            execute_op = 3'd7;
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, out_valid, 1'b1);
            chk({tag, " hold vect_out"}, vect_out, exp_vec);
            chk({tag, " hold pc_out"}, pc_wr_en_out, exp_br);
            chk({tag, " hold in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, " post out_valid"}, out_valid, 1'b0);
        chk({tag, " post pc_out"}, pc_wr_en_out, 1'b0);
        chk({tag, " post vect_out"}, vect_out, exp_vec);
        chk({tag, " post in_ready"}, in_ready, 1'b1);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic          ovw;
        logic [2:0]    br;
        logic [VS-1:0] mask;
        logic [RS-1:0] a;
        logic [RS-1:0] b;
        logic [RS-1:0] res;    // result in active elements; masked ones keep a
        logic [1:0]    flags;  // {Z,N} after the op
        logic          br_out;
        int            hold;
    } rec_t;

    rec_t tbl[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v1, v2, ev;
        logic [1:0] mflags;
        logic [RS-1:0] r;
        logic n_acc, z_acc, ebr;
        logic [2:0] op, br;
        logic [VS-1:0] mask;
        logic ovw;

        tbl[0]  = '{3'd0, 1'b1, 3'b000, 16'hFFFF, 8'h7F, 8'h01, 8'h80, 2'b01, 1'b0, 5};
        tbl[1]  = '{3'd1, 1'b1, 3'b001, 16'hFFFF, 8'h05, 8'h05, 8'h00, 2'b10, 1'b1, 0};
        tbl[2]  = '{3'd0, 1'b0, 3'b010, 16'hFFFF, 8'h01, 8'h01, 8'h02, 2'b10, 1'b1, 0};
        tbl[3]  = '{3'd3, 1'b0, 3'b100, 16'hFFFF, 8'h01, 8'h00, 8'h01, 2'b10, 1'b0, 1};
        tbl[4]  = '{3'd4, 1'b1, 3'b000, 16'h00FF, 8'hAA, 8'hFF, 8'h55, 2'b00, 1'b0, 0};
        tbl[5]  = '{3'd2, 1'b1, 3'b100, 16'h0000, 8'hC3, 8'h0F, 8'hC3, 2'b10, 1'b1, 0};
        tbl[6]  = '{3'd5, 1'b1, 3'b010, 16'hFFFF, 8'h81, 8'h09, 8'h02, 2'b00, 1'b1, 0};
        tbl[7]  = '{3'd6, 1'b1, 3'b100, 16'hFFFF, 8'h80, 8'h07, 8'h01, 2'b00, 1'b1, 0};
        tbl[8]  = '{3'd0, 1'b1, 3'b001, 16'hFFFF, 8'hFF, 8'h01, 8'h00, 2'b10, 1'b0, 0};
        tbl[9]  = '{3'd7, 1'b0, 3'b010, 16'hFFFF, 8'h9A, 8'h11, 8'h9A, 2'b10, 1'b1, 2};
        tbl[10] = '{3'd1, 1'b1, 3'b111, 16'hFFFF, 8'h00, 8'h01, 8'hFF, 2'b01, 1'b0, 0};
        tbl[11] = '{3'd2, 1'b1, 3'b001, 16'hFFFF, 8'hF0, 8'h3C, 8'h30, 2'b00, 1'b1, 0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        execute_op = '0; overwrite_flags = 1'b0; pc_wr_en = '0;
        lane_mask = '0; vect1 = '0; vect2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset vect_out", vect_out, '0);
        chk("reset nz_flags", nz_flags, 2'b00);
        chk("reset pc_out", pc_wr_en_out, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            v1 = {VS{tbl[i].a}};
            v2 = {VS{tbl[i].b}};
            for (int e = 0; e < VS; e++) ev[e] = tbl[i].mask[e] ? tbl[i].res : tbl[i].a;
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].ovw, tbl[i].br, tbl[i].mask,
                  v1, v2, ev, tbl[i].flags, tbl[i].br_out, tbl[i].hold);
        end

        // Reset in the middle of RUN, with non-zero flags beforehand.
        do_op("pre_rst", 3'd0, 1'b1, 3'b000, 16'hFFFF, {VS{8'hFF}}, {VS{8'h01}},
              {VS{8'h00}}, 2'b10, 1'b0, 0);
        execute_op = 3'd0; overwrite_flags = 1'b1; lane_mask = 16'hFFFF;
        vect1 = {VS{8'h11}}; vect2 = {VS{8'h11}}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrun in_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrun rst out_valid", out_valid, 1'b0);
        chk("midrun rst vect_out", vect_out, '0);
        chk("midrun rst nz_flags", nz_flags, 2'b00);
        chk("midrun rst pc_out", pc_wr_en_out, 1'b0);
        chk("midrun rst in_ready", in_ready, 1'b1);
        do_op("post_rst", 3'd1, 1'b1, 3'b100, 16'hFFFF, {VS{8'h10}}, {VS{8'h01}},
              {VS{8'h0F}}, 2'b00, 1'b1, 0);

        // Randomized ops against the model.
        mflags = 2'b00;
        for (int t = 0; t < 24; t++) begin
            op   = 3'($urandom_range(0, 7));
            ovw  = 1'($urandom_range(0, 1));
            br   = 3'($urandom_range(0, 7));
            mask = 16'($urandom);
            if (t % 6 == 0) mask = '0;
            for (int e = 0; e < VS; e++) begin
                v1[e] = 8'($urandom);
                v2[e] = 8'($urandom);
                if (t % 5 == 0) v2[e] = v1[e];
            end
            n_acc = 1'b0; z_acc = 1'b1;
            for (int e = 0; e < VS; e++) begin
                r = ref_elem(op, v1[e], v2[e]);
                ev[e] = mask[e] ? r : v1[e];
                if (mask[e]) begin
                    if (r >= 8'h80) n_acc = 1'b1;
                    if (r != 0) z_acc = 1'b0;
                end
            end
            ebr = ref_branch(br, mflags);
            if (ovw) mflags = {z_acc, n_acc};
            do_op($sformatf("rnd%0d", t), op, ovw, br, mask, v1, v2, ev, mflags, ebr,
                  int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
